// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the PC, captures opcode/operand bytes from the
// registered-read memory and hands complete instructions to decode. Optional HALT opcode support: `FETCH_HALT_EN.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; while valid and not ready, instr_* hold stable.
  typedef enum logic [2:0] {
    A_OP  = 3'd0,
    C_OP  = 3'd1,
    A_ARG = 3'd2,
    C_ARG = 3'd3,
    VALID = 3'd4
`ifdef FETCH_HALT_EN
    , HALT = 3'd5
`endif
  } state_t;

`ifdef FETCH_HALT_EN
  localparam logic [DATA_W-1:0] HALT_OP = DATA_W'(8'h7F);
`endif

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;

  assign mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= A_OP;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (jump_en) begin
      state_next = A_OP;
    end else begin
      case (state)
        A_OP:    state_next = C_OP;
        C_OP:    state_next = mem_data[DATA_W-1] ? A_ARG : VALID;
        A_ARG:   state_next = C_ARG;
        C_ARG:   state_next = VALID;
        VALID: begin
          if (instr_ready) begin
`ifdef FETCH_HALT_EN
            state_next = (instr_opcode == HALT_OP) ? HALT : A_OP;
`else
            state_next = A_OP;
`endif
          end
        end
`ifdef FETCH_HALT_EN
        HALT:    state_next = HALT;
`endif
        default: state_next = A_OP;
      endcase
    end
  end

  always_comb begin
    instr_valid = (state == VALID);
`ifdef FETCH_HALT_EN
    halted      = (state == HALT);
`else
    halted      = 1'b0;
`endif
  end

  // A jump wins over any capture in flight; the partial instruction is simply abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_pc      <= '0;
    end else if (jump_en) begin
      pc <= jump_addr;
    end else begin
      case (state)
        C_OP: begin
          instr_opcode <= mem_data;
          instr_pc     <= pc;
          pc           <= pc + ADDR_W'(1);
          if (!mem_data[DATA_W-1]) instr_operand <= '0;
        end
        C_ARG: begin
          instr_operand <= mem_data;
          pc            <= pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
